// File: rtl/ab_eval_sched.sv
// rtl/ab_eval_sched.sv - round-robin sequencer time-sharing one A/B evaluation cell across NREQ requesters
// Define AB_EVAL_FASTPATH_EN for two cell copies and a two-phase evaluation.
module ab_eval_sched #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_x,
  input  logic [NREQ-1:0]  req_y,
  output logic [NREQ-1:0]  gnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_z,
  output logic             busy,
  output logic [CNT_W-1:0] eval_count
);

`ifdef AB_EVAL_FASTPATH_EN
  typedef enum logic [1:0] {IDLE, EVAL_P1, EVAL_P2, RESP} state_t;
  localparam state_t FIRST_EVAL = EVAL_P1;
`else
  typedef enum logic [2:0] {IDLE, EVAL_A1, EVAL_B1, EVAL_A2, EVAL_B2, RESP} state_t;
  localparam state_t FIRST_EVAL = EVAL_A1;
`endif

  localparam logic [ID_W:0]   NREQ_EXT = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NREQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic            win_found;
  logic [ID_W:0]   scan;
  logic            x_q, y_q;
  logic            a1, b1, a2, b2;

  // Rotating search: first active request at or above the pointer, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan >= NREQ_EXT) scan = scan - NREQ_EXT;
      if (!win_found && req[scan[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    case (state)
      IDLE: begin
        if (win_found && rst_n) begin
          gnt[win_idx] = 1'b1;
          state_nxt    = FIRST_EVAL;
        end
      end
`ifdef AB_EVAL_FASTPATH_EN
      EVAL_P1: state_nxt = EVAL_P2;
      EVAL_P2: state_nxt = RESP;
`else
      EVAL_A1: state_nxt = EVAL_B1;
      EVAL_B1: state_nxt = EVAL_A2;
      EVAL_A2: state_nxt = EVAL_B2;
      EVAL_B2: state_nxt = RESP;
`endif
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AB_EVAL_FASTPATH_EN
  logic cell_a, cell_b;
  assign cell_a = x_q & ~y_q;
  assign cell_b = ~(x_q ^ y_q);
`else
  // The single cell is steered to the B function only during the B phases.
  logic cell_fn_b, cell_out;
  assign cell_fn_b = (state == EVAL_B1) || (state == EVAL_B2);
  assign cell_out  = cell_fn_b ? ~(x_q ^ y_q) : (x_q & ~y_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      x_q        <= 1'b0;
      y_q        <= 1'b0;
      rsp_id     <= '0;
      a1         <= 1'b0;
      b1         <= 1'b0;
      a2         <= 1'b0;
      b2         <= 1'b0;
      eval_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            x_q    <= req_x[win_idx];
            y_q    <= req_y[win_idx];
            rsp_id <= win_idx;
            rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          end
        end
`ifdef AB_EVAL_FASTPATH_EN
        EVAL_P1: begin
          a1 <= cell_a;
          b1 <= cell_b;
        end
        EVAL_P2: begin
          a2 <= cell_a;
          b2 <= cell_b;
        end
`else
        EVAL_A1: a1 <= cell_out;
        EVAL_B1: b1 <= cell_out;
        EVAL_A2: a2 <= cell_out;
        EVAL_B2: b2 <= cell_out;
`endif
        RESP: if (rsp_ready) eval_count <= eval_count + 1'b1;
        default: ;
      endcase
    end
  end

  // Phase registers only move during evaluation, so z is stable throughout RESP.
  assign rsp_z = (a1 | b1) ^ (a2 & b2);

endmodule

// File: tb/tb_ab_eval_sched.sv
// tb/tb_ab_eval_sched.sv - self-checking bench for ab_eval_sched with a transaction-level reference model
module tb_ab_eval_sched;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 8;
`ifdef AB_EVAL_FASTPATH_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 5;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  req_x = '0;
  logic [NREQ-1:0]  req_y = '0;
  logic [NREQ-1:0]  gnt;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_z;
  logic             busy;
  logic [CNT_W-1:0] eval_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ab_eval_sched #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .busy(busy), .eval_count(eval_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // z is 0 only for x=0, y=1.
  function automatic int ref_z(input logic x, input logic y);
    return (!x && y) ? 0 : 1;
  endfunction

  // Model: cycles since grant (0 = idle), owner, result, pointer and accept count.
  int m_phase = 0, m_ptr = 0, m_id = 0, m_z = 0, m_count = 0;

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] eg;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_count = 0;
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", eval_count, 0);
    end else begin
      eg = '0;
      w  = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req[idx]) w = idx;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", gnt, eg);
      chk("busy", busy, m_phase != 0);
      chk("rsp_valid", rsp_valid, m_phase == LAT);
      chk("eval_count", eval_count, m_count % (1 << CNT_W));
      if (m_phase == LAT) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_z", rsp_z, m_z);
      end
      if (w >= 0) begin
        m_id = w; m_z = ref_z(req_x[w], req_y[w]);
        m_ptr = (w + 1) % NREQ; m_phase = 1;
      end else if (m_phase > 0 && m_phase < LAT) begin
        m_phase++;
      end else if (m_phase == LAT && rsp_ready) begin
        m_count++; m_phase = 0;
      end
    end
  end

  task automatic wait_gnt(input int r, input string name);
    int n = 0;
    @(negedge clk);
    while (!gnt[r] && n < 100) begin @(negedge clk); n++; end
    chk(name, gnt[r], 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk(name, rsp_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("drain_idle", busy, 0);
  endtask

  task automatic run_one(input int r, input logic x, input logic y,
                         output logic z, output logic [ID_W-1:0] id);
    @(posedge clk); #1;
    req_x[r] = x; req_y[r] = y; req[r] = 1'b1;
    wait_gnt(r, "tt_gnt");
    @(posedge clk); #1 req[r] = 1'b0;
    wait_valid("tt_valid");
    z = rsp_z; id = rsp_id;
    @(posedge clk); #1;
  endtask

  int tt_exp[4] = '{1, 0, 1, 1};
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int order[$];

  initial begin
    logic z;
    logic [ID_W-1:0] id;
    logic [NREQ-1:0] lg;
    int n, acc;

    // Reset with all requesters active
    req = 4'b1111;
    repeat (2) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", gnt, 4'b0001);
    @(posedge clk); #1 rst_n = 1'b0; req = '0;
    @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 1'b1;

    // Single request on requester 2
    req_x = 4'b0100; req_y = 4'b0000; req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1 req = '0;
      @(negedge clk);
      chk("single_valid", rsp_valid, k == LAT);
    end
    chk("single_id", rsp_id, 2);
    chk("single_z", rsp_z, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_count", eval_count, 1);

    // Truth table through requester 0
    for (int t = 0; t < 4; t++) begin
      logic [1:0] xy;
      xy = 2'(t);
      run_one(0, xy[1], xy[0], z, id);
      chk("tt_z", z, tt_exp[t]);
      chk("tt_id", id, 0);
    end

    // Round robin with all requests held
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req_x = 4'($urandom_range(0, 15)); req_y = 4'($urandom_range(0, 15)); req = 4'b1111;
    n = 0;
    while (order.size() < 5 && n < 100) begin
      @(negedge clk); n++;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
    end
    chk("rr_grants", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) chk("rr_order", order[i], rr_exp[i]);
    @(posedge clk); #1 req = '0;
    drain();

    // Backpressure on requester 1
    @(posedge clk); #1 rsp_ready = 1'b0;
    req_x[1] = 1'b1; req_y[1] = 1'b1; req[1] = 1'b1;
    wait_gnt(1, "bp_gnt");
    wait_valid("bp_valid_rise");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_z", rsp_z, 1);
      chk("bp_gnt", gnt, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_regrant", gnt, 4'b0010);
    @(posedge clk); #1 req = '0;
    drain();

    // Reset during the second evaluation phase
    @(posedge clk); #1 req_x[0] = 1'b1; req_y[0] = 1'b1; req = 4'b0001;
    wait_gnt(0, "mid_gnt");
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_valid", rsp_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end

    // Randomized traffic until 256 accepts, then the counter must have wrapped
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    acc = 0; n = 0;
    while (acc < 256 && n < 20000) begin
      @(negedge clk); n++;
      if (rsp_valid && rsp_ready) acc++;
      lg = gnt;
      if (acc == 256) break;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (lg[i] || !req[i]) begin
          req[i] = (lg[i] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0));
          req_x[i] = 1'($urandom_range(0, 1));
          req_y[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    chk("rand_accepts", acc, 256);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("wrap_count", eval_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
